imem_fetch_responder: RTL and testbench

Instruction-side memory responder for the core's fetch port. It accepts the predicted fetch address each cycle and returns the 32-bit instruction word one cycle later. The block contains a direct-mapped instruction cache. Misses are refilled from a backing memory through a req/ready handshake followed by burst beats. A combinational stall tells the core to hold its fetch address while a refill is in progress.

---
 rtl/imem_fetch_responder_if.sv | 40 ++++
 rtl/imem_fetch_responder.sv | 136 +++++++++++++
 tb/tb_imem_fetch_responder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_responder_if.sv
// Fetch-port and refill-port signal bundle for the instruction memory responder.
// The slave modport is the responder's view; master is the core/backing-memory side.
interface imem_fetch_responder_if;
    logic [31:0] req_addr;
    logic [31:0] resp_inst;
    logic        resp_valid;
    logic        stall;
    logic        flush;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    modport slave (
        input  req_addr,
        input  flush,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data,
        output resp_inst,
        output resp_valid,
        output stall,
        output mem_req_valid,
        output mem_req_addr
    );

    modport master (
        output req_addr,
        output flush,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data,
        input  resp_inst,
        input  resp_valid,
        input  stall,
        input  mem_req_valid,
        input  mem_req_addr
    );
endinterface

// File: rtl/imem_fetch_responder.sv
// Direct-mapped instruction cache answering the core's fetch port one cycle after
// the address, refilling whole lines from backing memory on a miss.
//
// state | meaning
// IDLE  | lookup active; a miss latches the line base and moves to REQ
// REQ   | line request held on mem_req_* until mem_req_ready
// FILL  | one refill beat written per mem_resp_valid; last beat returns to IDLE
module imem_fetch_responder #(
    parameter int          LINES          = 16,
    parameter int          WORDS_PER_LINE = 4,
    parameter logic [31:0] NOP_INST       = 32'h0000_0013
) (
    input logic                  clk,
    input logic                  rst,
    imem_fetch_responder_if.slave bus
);
    localparam int OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int IDX_W   = $clog2(LINES);
    localparam int TAG_LSB = 2 + OFF_W + IDX_W;
    localparam int TAG_W   = 32 - TAG_LSB;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL
    } state_t;

    state_t            state_q;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [31:0]       data_q [LINES*WORDS_PER_LINE];
    logic              flush_pending_q;
    logic [OFF_W-1:0]  beat_q;
    logic              mem_req_valid_q;
    logic [31:0]       mem_req_addr_q;
    logic              resp_valid_q;
    logic [31:0]       resp_inst_q;

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic [31:0]       rd_word;
    logic              hit;
    logic              fill_beat;
    logic              fill_last;
    logic              unused_addr_bits;

    assign req_off  = bus.req_addr[2 +: OFF_W];
    assign req_idx  = bus.req_addr[2+OFF_W +: IDX_W];
    assign req_tag  = bus.req_addr[TAG_LSB +: TAG_W];
    assign fill_idx = mem_req_addr_q[2+OFF_W +: IDX_W];
    assign fill_tag = mem_req_addr_q[TAG_LSB +: TAG_W];
    assign rd_word  = data_q[{req_idx, req_off}];
    assign unused_addr_bits = ^bus.req_addr[1:0];

    // A flush in IDLE suppresses the hit so the core holds and re-fetches cleanly.
    assign hit = (state_q == IDLE) && valid_q[req_idx] &&
                 (tag_q[req_idx] == req_tag) && !bus.flush;

    assign fill_beat = (state_q == FILL) && bus.mem_resp_valid;
    assign fill_last = fill_beat && (beat_q == LAST_BEAT);

    assign bus.stall         = (state_q != IDLE) || !hit;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_inst     = resp_inst_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = mem_req_addr_q;

    always_ff @(posedge clk) begin
        if (fill_beat) begin
            data_q[{fill_idx, beat_q}] <= bus.mem_resp_data;
        end
        if (fill_last) begin
            tag_q[fill_idx] <= fill_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            valid_q         <= '0;
            flush_pending_q <= 1'b0;
            beat_q          <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            resp_valid_q    <= 1'b0;
            resp_inst_q     <= NOP_INST;
        end else begin
            resp_valid_q <= hit;
            resp_inst_q  <= hit ? rd_word : NOP_INST;
            case (state_q)
                IDLE: begin
                    if (bus.flush) begin
                        valid_q <= '0;
                    end else if (!hit) begin
                        mem_req_addr_q  <= {bus.req_addr[31:2+OFF_W], {(2+OFF_W){1'b0}}};
                        mem_req_valid_q <= 1'b1;
                        state_q         <= REQ;
                    end
                end
                REQ: begin
                    if (bus.flush) begin
                        flush_pending_q <= 1'b1;
                    end
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        beat_q          <= '0;
                        state_q         <= FILL;
                    end
                end
                FILL: begin
                    if (bus.flush) begin
                        flush_pending_q <= 1'b1;
                    end
                    if (bus.mem_resp_valid) begin
                        beat_q <= beat_q + OFF_W'(1);
                        if (beat_q == LAST_BEAT) begin
                            state_q <= IDLE;
                            // A flush seen during the refill discards this line and all others.
                            if (flush_pending_q || bus.flush) begin
                                valid_q         <= '0;
                                flush_pending_q <= 1'b0;
                            end else begin
                                valid_q[fill_idx] <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder: a small backing-memory model serves refills,
// and each vector compares a DUT output against a hand-derived value.
module tb_imem_fetch_responder;
    localparam int WPL = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_fetch_responder_if bus();

    imem_fetch_responder #(
        .LINES(16),
        .WORDS_PER_LINE(4),
        .NOP_INST(32'h0000_0013)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic        filling     = 1'b0;
    int          beat_idx    = 0;
    logic [31:0] fill_base   = '0;
    logic        junk        = 1'b0;
    int          flush_beat  = -1;
    int          req_seen    = 0;

    // Backing memory content: addi x(w+1), x0, w for word address w.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        return (w << 20) + (((w + 32'd1) & 32'h1f) << 7) + 32'h13;
    endfunction

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic        hs;
        logic        bt;
        logic [31:0] la;
        hs = bus.mem_req_valid && bus.mem_req_ready;
        bt = bus.mem_resp_valid && filling;
        la = bus.mem_req_addr;
        @(posedge clk);
        @(negedge clk);
        if (hs) begin
            filling   = 1'b1;
            beat_idx  = 0;
            fill_base = la;
            req_seen++;
        end else if (bt) begin
            beat_idx++;
            if (beat_idx == WPL) filling = 1'b0;
        end
        bus.flush = 1'b0;
        if (filling) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = mem_word(fill_base + 32'(4 * beat_idx));
            if (beat_idx == flush_beat) begin
                bus.flush  = 1'b1;
                flush_beat = -1;
            end
        end else if (junk) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 32'hdead_beef;
        end else begin
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = '0;
        end
        #1;
    endtask

    // Presents addr from the current cycle until the stall drops, then checks the hit word.
    task automatic fetch_miss(input string tag, input logic [31:0] addr,
                              input int ready_delay, input int exp_reqs);
        int n;
        int rq;
        n  = 0;
        rq = 0;
        req_seen = 0;
        bus.req_addr      = addr;
        bus.mem_req_ready = (ready_delay == 0);
        #1;
        while (bus.stall && n < 60) begin
            if (bus.mem_req_valid) begin
                check_vec({tag, " req addr"}, bus.mem_req_addr, {addr[31:4], 4'h0});
                bus.mem_req_ready = (rq >= ready_delay);
                junk = (rq < ready_delay);
                rq++;
            end
            n++;
            step();
        end
        check_vec({tag, " stall cycles"}, 32'(n), 32'(6 * exp_reqs + ready_delay));
        check_vec({tag, " requests"}, 32'(req_seen), 32'(exp_reqs));
        bus.mem_req_ready = 1'b1;
        junk = 1'b0;
        step();
        check_vec({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
        check_vec({tag, " resp_inst"}, bus.resp_inst, mem_word(addr));
    endtask

    initial begin
        logic [31:0] seq_addr [3];
        logic [31:0] seq_inst [3];
        int n;
        seq_addr = '{32'h4, 32'h8, 32'hC};
        seq_inst = '{32'h0010_0113, 32'h0020_0193, 32'h0030_0213};

        rst                = 1'b0;
        bus.req_addr       = '0;
        bus.flush          = 1'b0;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        #12;
        check_vec("reset resp_valid", 32'(bus.resp_valid), 32'd0);
        check_vec("reset resp_inst", bus.resp_inst, 32'h0000_0013);
        check_vec("reset mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        check_vec("reset mem_req_addr", bus.mem_req_addr, 32'h0);
        check_vec("reset stall", 32'(bus.stall), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;

        fetch_miss("fill0", 32'h0, 0, 1);
        check_vec("fill0 first word", bus.resp_inst, 32'h0000_0093);
        for (int i = 0; i < 3; i++) begin
            bus.req_addr = seq_addr[i];
            #1;
            check_vec("seq stall", 32'(bus.stall), 32'd0);
            check_vec("seq mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
            step();
            check_vec("seq resp_valid", 32'(bus.resp_valid), 32'd1);
            check_vec("seq resp_inst", bus.resp_inst, seq_inst[i]);
        end

        fetch_miss("conflict100", 32'h100, 0, 1);
        fetch_miss("conflict000", 32'h0, 0, 1);
        fetch_miss("conflict100b", 32'h100, 0, 1);

        fetch_miss("ready_delay", 32'h240, 5, 1);
        bus.req_addr = 32'h24C;
        #1;
        step();
        check_vec("ready_delay last word", bus.resp_inst, mem_word(32'h24C));

        fetch_miss("refill0", 32'h0, 0, 1);
        bus.flush = 1'b1;
        #1;
        check_vec("idle flush stall", 32'(bus.stall), 32'd1);
        step();
        check_vec("idle flush no req", 32'(bus.mem_req_valid), 32'd0);
        fetch_miss("post_flush", 32'h0, 0, 1);

        flush_beat = 1;
        fetch_miss("fill_flush", 32'h300, 0, 2);
        fetch_miss("fill_flush_clears", 32'h240, 0, 1);

        fetch_miss("pre_rst", 32'h0, 0, 1);
        bus.req_addr = 32'h380;
        #1;
        n = 0;
        while (!(filling && beat_idx == 2) && n < 30) begin
            n++;
            step();
        end
        check_vec("rst reached beat2", 32'(n < 30), 32'd1);
        rst = 1'b0;
        #1;
        check_vec("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check_vec("rst resp_inst", bus.resp_inst, 32'h0000_0013);
        check_vec("rst mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        check_vec("rst mem_req_addr", bus.mem_req_addr, 32'h0);
        check_vec("rst stall", 32'(bus.stall), 32'd1);
        filling = 1'b0;
        junk    = 1'b1;
        step();
        step();
        bus.req_addr = 32'h0;
        rst = 1'b1;
        #1;
        fetch_miss("post_rst", 32'h0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
